// File: rtl/pipe_stage_elastic.sv
// Elastic inter-stage register for LANES independent payload slots with valid/ready
// handshakes, optional 2-entry skid per lane, lockstep advance, flush and a stall counter.
module pipe_stage_elastic #(
  parameter int LANES    = 2,
  parameter int WIDTH    = 128,
  parameter int SKID     = 1,
  parameter int LOCKSTEP = 1,
  parameter int CNT_W    = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [LANES-1:0]       in_valid,
  output logic [LANES-1:0]       in_ready,
  input  logic [LANES*WIDTH-1:0] in_data,
  input  logic [LANES-1:0]       flush,
  output logic [LANES-1:0]       out_valid,
  input  logic [LANES-1:0]       out_ready,
  output logic [LANES*WIDTH-1:0] out_data,
  input  logic                   stat_clr,
  output logic [CNT_W-1:0]       stall_cnt
);

  logic [LANES-1:0]            main_vld_q, main_vld_d;
  logic [LANES-1:0]            skid_vld_q, skid_vld_d;
  logic [LANES-1:0][WIDTH-1:0] main_q, main_d;
  logic [LANES-1:0][WIDTH-1:0] skid_q, skid_d;
  logic [CNT_W-1:0]            stall_cnt_q, stall_cnt_d;

  logic [LANES-1:0] dn_rdy;
  logic [LANES-1:0] int_rdy;
  logic [LANES-1:0] up_rdy;
  logic [LANES-1:0] acc;
  logic [LANES-1:0] pop;
  logic             stall;

  // In lockstep mode every lane sees the same combined downstream/upstream readiness.
  assign dn_rdy = (LOCKSTEP != 0) ? {LANES{&out_ready}} : out_ready;

  always_comb begin
    int_rdy = '0;
    for (int i = 0; i < LANES; i++) begin
      if (SKID != 0) int_rdy[i] = ~skid_vld_q[i];
      else           int_rdy[i] = ~main_vld_q[i] | dn_rdy[i];
    end
  end

  assign up_rdy    = (LOCKSTEP != 0) ? {LANES{&int_rdy}} : int_rdy;
  assign in_ready  = up_rdy;
  assign acc       = in_valid & up_rdy;
  assign pop       = main_vld_q & dn_rdy;
  assign stall     = |(main_vld_q & ~dn_rdy);
  assign out_valid = main_vld_q;
  assign out_data  = main_q;
  assign stall_cnt = stall_cnt_q;

  always_comb begin
    // NOTE: every next-state signal gets its hold value first so no path leaves it unassigned (no latches).
    main_vld_d = main_vld_q;
    skid_vld_d = skid_vld_q;
    main_d     = main_q;
    skid_d     = skid_q;
    for (int i = 0; i < LANES; i++) begin
      if (flush[i]) begin
        // Kill both entries; data registers keep their stale contents.
        main_vld_d[i] = 1'b0;
        skid_vld_d[i] = 1'b0;
      end else if (SKID != 0) begin
        if (skid_vld_q[i]) begin
          if (pop[i]) begin
            main_d[i]     = skid_q[i];
            skid_vld_d[i] = 1'b0;
          end
        end else if (main_vld_q[i]) begin
          if (acc[i] && !pop[i]) begin
            skid_d[i]     = in_data[i*WIDTH +: WIDTH];
            skid_vld_d[i] = 1'b1;
          end else if (acc[i]) begin
            main_d[i] = in_data[i*WIDTH +: WIDTH];
          end else if (pop[i]) begin
            main_vld_d[i] = 1'b0;
          end
        end else if (acc[i]) begin
          main_d[i]     = in_data[i*WIDTH +: WIDTH];
          main_vld_d[i] = 1'b1;
        end
      end else begin
        if (acc[i]) begin
          main_d[i]     = in_data[i*WIDTH +: WIDTH];
          main_vld_d[i] = 1'b1;
        end else if (pop[i]) begin
          main_vld_d[i] = 1'b0;
        end
      end
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stat_clr)                         stall_cnt_d = '0;
    else if (stall && stall_cnt_q != '1)  stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous and also clears the payload registers, so out_data reads 0 after reset.
    if (reset) begin
      main_vld_q  <= '0;
      skid_vld_q  <= '0;
      main_q      <= '0;
      skid_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      main_vld_q  <= main_vld_d;
      skid_vld_q  <= skid_vld_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule
